// File: rtl/vol_sample_sequencer.sv
// vol_sample_sequencer: top-of-book intake for the volatility path.
// Buffers updates in a small FIFO, tags each emitted sample with its slot in the
// per-stock circular sample memory, and reports window size and Q32.32 reciprocal.
// Optional build macro: SKIP_UNCHANGED_EN drops quotes identical to the last one
// emitted for the same stock.
module vol_sample_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int FP_WORD_SIZE = 64,
  parameter int BUFFER_SIZE  = 32,
  parameter int NUM_STOCKS   = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic                                    i_valid,
  output logic                                    o_ready,
  input  logic [$clog2(NUM_STOCKS)-1:0]           i_stock_id,
  input  logic [DATA_WIDTH-1:0]                   i_best_bid,
  input  logic [DATA_WIDTH-1:0]                   i_best_ask,
  input  logic                                    i_stall,
  output logic                                    o_valid,
  output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0] o_write_address,
  output logic [$clog2(NUM_STOCKS)-1:0]           o_stock_id,
  output logic [DATA_WIDTH-1:0]                   o_best_bid,
  output logic [DATA_WIDTH-1:0]                   o_best_ask,
  output logic [DATA_WIDTH-1:0]                   o_buffer_size,
  output logic [FP_WORD_SIZE-1:0]                 o_buffer_size_reciprocal,
  output logic [$clog2(BUFFER_SIZE):0]            o_fill_count,
  output logic [15:0]                             o_drop_count
);

  localparam int SW = $clog2(NUM_STOCKS);
  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int FW = PW + 1;
  localparam int QW = $clog2(FIFO_DEPTH);
  localparam logic [FW-1:0] FILL_MAX = FW'(BUFFER_SIZE);
  localparam logic [FP_WORD_SIZE-1:0] RECIP = FP_WORD_SIZE'((64'd1 << 32) / 64'(BUFFER_SIZE));

  logic [SW-1:0]         q_stock [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_bid   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_ask   [FIFO_DEPTH];
  logic [QW-1:0]         wr_idx;
  logic [QW-1:0]         rd_idx;
  logic [QW:0]           q_count;

  logic                  push;
  logic                  pop;
  logic                  zero_quote;
  logic                  skip_same;
  logic                  drop;
  logic                  emit;
  logic [SW-1:0]         h_stock;
  logic [DATA_WIDTH-1:0] h_bid;
  logic [DATA_WIDTH-1:0] h_ask;

  logic [PW-1:0]         ptr  [NUM_STOCKS];
  logic [FW-1:0]         fill [NUM_STOCKS];
  logic [FW-1:0]         fill_next;

  // No bypass: a full FIFO refuses a push even on a pop edge.
  assign o_ready    = (q_count < (QW+1)'(FIFO_DEPTH));
  assign push       = i_valid && o_ready;
  assign pop        = (q_count != '0) && !i_stall;

  assign h_stock    = q_stock[rd_idx];
  assign h_bid      = q_bid[rd_idx];
  assign h_ask      = q_ask[rd_idx];

  assign zero_quote = (h_bid == '0) && (h_ask == '0);
  assign drop       = zero_quote || skip_same;
  assign emit       = pop && !drop;
  assign fill_next  = (fill[h_stock] == FILL_MAX) ? FILL_MAX : fill[h_stock] + FW'(1);

  assign o_buffer_size            = DATA_WIDTH'(BUFFER_SIZE);
  assign o_buffer_size_reciprocal = RECIP;

  // FIFO storage; contents are don't-care while the count says empty, so no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_stock[wr_idx] <= i_stock_id;
      q_bid[wr_idx]   <= i_best_bid;
      q_ask[wr_idx]   <= i_best_ask;
    end
  end

  // FIFO indices and occupancy.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + QW'(1);
      if (pop)  rd_idx <= rd_idx + QW'(1);
      if (push && !pop)      q_count <= q_count + (QW+1)'(1);
      else if (pop && !push) q_count <= q_count - (QW+1)'(1);
    end
  end

  // Per-stock circular write pointer and saturating fill level, advanced only on emit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        ptr[s]  <= '0;
        fill[s] <= '0;
      end
    end else if (emit) begin
      ptr[h_stock]  <= ptr[h_stock] + PW'(1);
      fill[h_stock] <= fill_next;
    end
  end

`ifdef SKIP_UNCHANGED_EN
  logic [DATA_WIDTH-1:0] last_bid [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_ask [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] seen;

  assign skip_same = seen[h_stock] && (last_bid[h_stock] == h_bid) && (last_ask[h_stock] == h_ask);

  // Remember the last quote actually emitted per stock.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      seen <= '0;
      for (int s = 0; s < NUM_STOCKS; s++) begin
        last_bid[s] <= '0;
        last_ask[s] <= '0;
      end
    end else if (emit) begin
      seen[h_stock]     <= 1'b1;
      last_bid[h_stock] <= h_bid;
      last_ask[h_stock] <= h_ask;
    end
  end
`else
  assign skip_same = 1'b0;
`endif

  // Registered sample outputs; data holds its last value when nothing is emitted.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid         <= 1'b0;
      o_write_address <= '0;
      o_stock_id      <= '0;
      o_best_bid      <= '0;
      o_best_ask      <= '0;
      o_fill_count    <= '0;
      o_drop_count    <= '0;
    end else begin
      o_valid <= emit;
      if (emit) begin
        o_write_address <= {h_stock, ptr[h_stock]};
        o_stock_id      <= h_stock;
        o_best_bid      <= h_bid;
        o_best_ask      <= h_ask;
        o_fill_count    <= fill_next;
      end
      if (pop && drop && (o_drop_count != 16'hFFFF))
        o_drop_count <= o_drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vol_sample_sequencer.sv
// Scoreboard bench for vol_sample_sequencer: stimulus pushes expected samples,
// a negedge monitor pops and compares whenever o_valid is seen.
module tb_vol_sample_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_stock_id;
  logic [31:0] i_best_bid;
  logic [31:0] i_best_ask;
  logic        i_stall;
  logic        o_valid;
  logic [6:0]  o_write_address;
  logic [1:0]  o_stock_id;
  logic [31:0] o_best_bid;
  logic [31:0] o_best_ask;
  logic [31:0] o_buffer_size;
  logic [63:0] o_buffer_size_reciprocal;
  logic [5:0]  o_fill_count;
  logic [15:0] o_drop_count;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0]  addr;
    logic [1:0]  stock;
    logic [31:0] bid;
    logic [31:0] ask;
    logic [5:0]  fill;
  } exp_t;

  exp_t sb[$];

  vol_sample_sequencer dut (
    .i_clk                    (i_clk),
    .i_reset                  (i_reset),
    .i_valid                  (i_valid),
    .o_ready                  (o_ready),
    .i_stock_id               (i_stock_id),
    .i_best_bid               (i_best_bid),
    .i_best_ask               (i_best_ask),
    .i_stall                  (i_stall),
    .o_valid                  (o_valid),
    .o_write_address          (o_write_address),
    .o_stock_id               (o_stock_id),
    .o_best_bid               (o_best_bid),
    .o_best_ask               (o_best_ask),
    .o_buffer_size            (o_buffer_size),
    .o_buffer_size_reciprocal (o_buffer_size_reciprocal),
    .o_fill_count             (o_fill_count),
    .o_drop_count             (o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Drive one update; waits (bounded) for o_ready, queues the expected sample if any.
  task automatic send(input logic [1:0] s, input logic [31:0] b, input logic [31:0] a,
                      input bit exp_out, input logic [6:0] ea, input logic [5:0] ef);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge i_clk);
    i_valid    = 1'b1;
    i_stock_id = s;
    i_best_bid = b;
    i_best_ask = a;
    while (!o_ready && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_ready) begin
      chk("ready_timeout", {63'd0, o_ready}, 64'd1);
    end else if (exp_out) begin
      e.addr  = ea;
      e.stock = s;
      e.bid   = b;
      e.ask   = a;
      e.fill  = ef;
      sb.push_back(e);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Monitor: every emitted sample must match the head of the scoreboard.
  initial begin
    forever begin : mon
      exp_t e;
      @(negedge i_clk);
      if (o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {63'd0, o_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("addr",  {57'd0, o_write_address}, {57'd0, e.addr});
          chk("stock", {62'd0, o_stock_id},      {62'd0, e.stock});
          chk("bid",   {32'd0, o_best_bid},      {32'd0, e.bid});
          chk("ask",   {32'd0, o_best_ask},      {32'd0, e.ask});
          chk("fill",  {58'd0, o_fill_count},    {58'd0, e.fill});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
    chk({tag, "_ready"}, {63'd0, o_ready}, 64'd1);
    chk({tag, "_drop"},  {48'd0, o_drop_count}, 64'd0);
    chk({tag, "_fill"},  {58'd0, o_fill_count}, 64'd0);
    chk({tag, "_addr"},  {57'd0, o_write_address}, 64'd0);
    chk({tag, "_bufsz"}, {32'd0, o_buffer_size}, 64'd32);
    chk({tag, "_recip"}, o_buffer_size_reciprocal, 64'h0000_0000_0800_0000);
  endtask

  initial begin
    int n;
    i_reset    = 1'b1;
    i_valid    = 1'b0;
    i_stall    = 1'b0;
    i_stock_id = '0;
    i_best_bid = '0;
    i_best_ask = '0;
    #1;
    chk_reset_state("rst0");
    idle(3);
    i_reset = 1'b0;

    // Single update: stock 2 -> address 64, visible exactly one cycle after the pop edge
    send(2'd2, 32'd100, 32'd102, 1'b1, 7'd64, 6'd1);
    @(negedge i_clk); chk("t2_before", {63'd0, o_valid}, 64'd0);
    @(negedge i_clk); chk("t2_pulse",  {63'd0, o_valid}, 64'd1);
    @(negedge i_clk); chk("t2_after",  {63'd0, o_valid}, 64'd0);

    // 33 updates to stock 0: wrap at 32, fill saturates at 32
    for (int i = 0; i < 33; i++)
      send(2'd0, 32'd1000 + 32'(i), 32'd1001 + 32'(i), 1'b1, 7'(i % 32), 6'((i < 32) ? i + 1 : 32));
    send(2'd1, 32'd5000, 32'd5001, 1'b1, 7'd32, 6'd1);
    idle(4);

    // Stalled: four accepted, fifth waits, then all five drain in order
    @(negedge i_clk);
    i_stall = 1'b1;
    for (int k = 0; k < 4; k++)
      send(2'd2, 32'd300 + 32'(k), 32'd310 + 32'(k), 1'b1, 7'(65 + k), 6'(2 + k));
    chk("t4_full_ready", {63'd0, o_ready}, 64'd0);
    fork
      send(2'd2, 32'd304, 32'd314, 1'b1, 7'd69, 6'd6);
    join_none
    idle(3);
    chk("t4_held_ready", {63'd0, o_ready}, 64'd0);
    chk("t4_held_valid", {63'd0, o_valid}, 64'd0);
    i_stall = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) n++;
    end
    chk("t4_pulses", 64'(n), 64'd5);
    wait fork;
    idle(3);

    // Zero quote dropped; next stock-1 sample takes the pending slot; one-sided book passes
    send(2'd1, 32'd0, 32'd0, 1'b0, 7'd0, 6'd0);
    idle(3);
    chk("t5_drop", {48'd0, o_drop_count}, 64'd1);
    send(2'd1, 32'd50, 32'd51, 1'b1, 7'd33, 6'd2);
    send(2'd1, 32'd0,  32'd77, 1'b1, 7'd34, 6'd3);
    idle(4);

    // Repeated identical quote on stock 3
    send(2'd3, 32'd200, 32'd204, 1'b1, 7'd96, 6'd1);
`ifdef SKIP_UNCHANGED_EN
    send(2'd3, 32'd200, 32'd204, 1'b0, 7'd0, 6'd0);
    idle(4);
    chk("t6_drop", {48'd0, o_drop_count}, 64'd2);
`else
    send(2'd3, 32'd200, 32'd204, 1'b1, 7'd97, 6'd2);
    idle(4);
    chk("t6_drop", {48'd0, o_drop_count}, 64'd1);
`endif

    // Reset mid-burst: queued entries vanish and the live pulse is cut
    @(negedge i_clk);
    i_stall = 1'b1;
    send(2'd0, 32'd7, 32'd8,  1'b0, 7'd0, 6'd0);
    send(2'd0, 32'd9, 32'd10, 1'b0, 7'd0, 6'd0);
    send(2'd0, 32'd3, 32'd4,  1'b0, 7'd0, 6'd0);
    @(negedge i_clk);
    i_stall = 1'b0;
    @(posedge i_clk);
    #2;
    chk("t7_prereset_valid", {63'd0, o_valid}, 64'd1);
    #1;
    i_reset = 1'b1;
    #1;
    chk_reset_state("rst1");
    idle(2);
    i_reset = 1'b0;
    idle(6);

    // Pointers restart from zero after reset
    send(2'd0, 32'd11, 32'd12, 1'b1, 7'd0, 6'd1);
    idle(4);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
